vrf_wr_arbiter: RTL and testbench



---
 rtl/vrf_pkg.sv | 18 +
 rtl/rr_arb2.sv | 33 +++
 rtl/vrf_wr_arbiter.sv | 105 ++++++++++
 tb/tb_vrf_wr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared VRF types and defaults for the write-port arbiter.
// Fixed-priority arbitration is selected with VRF_WARB_FIXED_PRIO_EN.
package vrf_pkg;
    localparam int VRF_LANES      = 4;
    localparam int VRF_DATA_WIDTH = 32;
    localparam int VRF_REG_NUM    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } warb_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wsrc_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, one-hot grant. The pointer toggles on advance_i.
// With VRF_WARB_FIXED_PRIO_EN defined, requester 0 always wins and the pointer is removed.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);
`ifdef VRF_WARB_FIXED_PRIO_EN
    logic unused_arb;
    assign unused_arb = ^{clk_i, resetn_i, advance_i};

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0])      gnt_o = 2'b01;
        else if (req_i[1]) gnt_o = 2'b10;
    end
`else
    logic ptr_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i)      ptr_q <= 1'b0;
        else if (advance_i) ptr_q <= ~ptr_q;
    end

    // Pointer only matters when both requesters compete.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
`endif
endmodule

// File: rtl/vrf_wr_arbiter.sv
// VRF write-port arbiter: grants ALU or LSU a whole vector and serialises its elements
// into the lane banks. VRF_WARB_FIXED_PRIO_EN selects fixed ALU priority.
module vrf_wr_arbiter
    import vrf_pkg::*;
#(
    parameter int  DATA_WIDTH = VRF_DATA_WIDTH,
    parameter int  REG_NUM    = VRF_REG_NUM,
    parameter int  LANES      = VRF_LANES,
    localparam int ADDR_B     = $clog2(REG_NUM),
    localparam int ELEM_B     = $clog2(LANES)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  alu_req_i,
    input  logic [ADDR_B-1:0]     alu_addr_i,
    input  logic                  alu_valid_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_req_i,
    input  logic [ADDR_B-1:0]     lsu_addr_i,
    input  logic                  lsu_valid_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    output logic                  alu_gnt_o,
    output logic                  lsu_gnt_o,
    output logic                  alu_ready_o,
    output logic                  lsu_ready_o,
    output logic                  wr_req_o,
    output logic                  wr_en_o,
    output logic                  wr_ready_o,
    output logic [ADDR_B-1:0]     wr_addr_o,
    output logic [ELEM_B-1:0]     wr_elem_cnt_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  busy_o
);
    localparam logic [ELEM_B-1:0] LAST_ELEM = ELEM_B'(LANES - 1);

    warb_state_t       state_q, state_d;
    wsrc_t             src_q;
    logic [ELEM_B-1:0] cnt_q;
    logic [ADDR_B-1:0] addr_q;
    logic [1:0]        arb_gnt;
    logic              sel_valid, accept, last;

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .req_i     ({lsu_req_i, alu_req_i}),
        .advance_i (last),
        .gnt_o     (arb_gnt)
    );

    assign sel_valid = (src_q == SRC_LSU) ? lsu_valid_i : alu_valid_i;
    assign accept    = (state_q == WRITE) && sel_valid;
    assign last      = accept && (cnt_q == LAST_ELEM);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        alu_gnt_o     = 1'b0;
        lsu_gnt_o     = 1'b0;
        alu_ready_o   = accept && (src_q == SRC_ALU);
        lsu_ready_o   = accept && (src_q == SRC_LSU);
        wr_req_o      = 1'b0;
        wr_en_o       = accept;
        wr_ready_o    = last;
        wr_addr_o     = addr_q;
        wr_elem_cnt_o = cnt_q;
        wdata_o       = '0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                alu_gnt_o = arb_gnt[0];
                lsu_gnt_o = arb_gnt[1];
                if (|arb_gnt) state_d = REQ;
            end
            REQ: begin
                wr_req_o = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                wdata_o = (src_q == SRC_LSU) ? lsu_data_i : alu_data_i;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Source and address are captured on grant and held for the whole vector.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            src_q  <= SRC_ALU;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && |arb_gnt) begin
                src_q  <= arb_gnt[1] ? SRC_LSU : SRC_ALU;
                addr_q <= arb_gnt[1] ? lsu_addr_i : alu_addr_i;
            end
            if (accept) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// Self-checking bench for vrf_wr_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_vrf_wr_arbiter;
    localparam int DW    = 32;
    localparam int RN    = 32;
    localparam int LANES = 4;
    localparam int AB    = 5;
    localparam int EB    = 2;

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic          alu_req_i, lsu_req_i, alu_valid_i, lsu_valid_i;
    logic [AB-1:0] alu_addr_i, lsu_addr_i;
    logic [DW-1:0] alu_data_i, lsu_data_i;
    logic          alu_gnt_o, lsu_gnt_o, alu_ready_o, lsu_ready_o;
    logic          wr_req_o, wr_en_o, wr_ready_o, busy_o;
    logic [AB-1:0] wr_addr_o;
    logic [EB-1:0] wr_elem_cnt_o;
    logic [DW-1:0] wdata_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    vrf_wr_arbiter #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LANES)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .alu_req_i(alu_req_i), .alu_addr_i(alu_addr_i), .alu_valid_i(alu_valid_i), .alu_data_i(alu_data_i),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_valid_i(lsu_valid_i), .lsu_data_i(lsu_data_i),
        .alu_gnt_o(alu_gnt_o), .lsu_gnt_o(lsu_gnt_o), .alu_ready_o(alu_ready_o), .lsu_ready_o(lsu_ready_o),
        .wr_req_o(wr_req_o), .wr_en_o(wr_en_o), .wr_ready_o(wr_ready_o), .wr_addr_o(wr_addr_o),
        .wr_elem_cnt_o(wr_elem_cnt_o), .wdata_o(wdata_o), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alu_req_i = 0; lsu_req_i = 0; alu_valid_i = 0; lsu_valid_i = 0;
        alu_addr_i = '0; lsu_addr_i = '0; alu_data_i = '0; lsu_data_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn_i = 0;
        tick(); tick();
        resetn_i = 1;
    endtask

    task automatic test_reset();
        logic [DW+AB+EB+7:0] act;
        idle_inputs();
        alu_valid_i = 1; alu_data_i = 32'h1234_5678;
        resetn_i = 0;
        tick(); tick();
        @(negedge clk_i);
        act = {alu_gnt_o, lsu_gnt_o, alu_ready_o, lsu_ready_o, wr_req_o, wr_en_o, wr_ready_o, busy_o,
               wr_addr_o, wr_elem_cnt_o, wdata_o};
        checks++;
        if (act !== '0) begin failures++; $display("FAIL reset_in got=%h exp=0", act); end
        tick(); resetn_i = 1; alu_valid_i = 0; tick();
        @(negedge clk_i);
        act = {alu_gnt_o, lsu_gnt_o, alu_ready_o, lsu_ready_o, wr_req_o, wr_en_o, wr_ready_o, busy_o,
               wr_addr_o, wr_elem_cnt_o, wdata_o};
        checks++;
        if (act !== '0) begin failures++; $display("FAIL reset_after got=%h exp=0", act); end
    endtask

    task automatic test_single_alu();
        logic [5:0] act, exp;
        logic [DW+AB+EB-1:0] dact, dexp;
        int k;
        logic en;
        do_reset();
        alu_req_i = 1; alu_addr_i = 5; alu_valid_i = 1; alu_data_i = 32'hA0;
        for (int c = 0; c < 7; c++) begin
            k  = (c < 2) ? 0 : c - 2;
            en = (c >= 2 && c <= 5);
            @(negedge clk_i);
            act = {alu_gnt_o, wr_req_o, wr_en_o, alu_ready_o, wr_ready_o, busy_o};
            exp = {c == 0, c == 1, en, en, c == 5, c >= 1 && c <= 5};
            checks++;
            if (act !== exp) begin failures++; $display("FAIL single_ctl c=%0d got=%b exp=%b", c, act, exp); end
            if (en) begin
                dact = {wr_elem_cnt_o, wr_addr_o, wdata_o};
                dexp = {EB'(k), AB'(5), 32'hA0 + DW'(k)};
                checks++;
                if (dact !== dexp) begin failures++; $display("FAIL single_data c=%0d got=%h exp=%h", c, dact, dexp); end
            end
            tick();
            alu_req_i  = 0;
            alu_data_i = 32'hA0 + DW'((c >= 1) ? c - 1 : 0);
            if (c >= 5) alu_valid_i = 0;
        end
    endtask

    task automatic test_rr();
        logic [1:0] gexp;
        int ng, exp_src, pend;
        do_reset();
        alu_req_i = 1; alu_addr_i = 3; alu_valid_i = 1; alu_data_i = 32'h11;
        lsu_req_i = 1; lsu_addr_i = 7; lsu_valid_i = 1; lsu_data_i = 32'h22;
        ng = 0; pend = -1; exp_src = 0;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            @(negedge clk_i);
            if (pend >= 0) begin
                checks++;
                if (wr_addr_o !== AB'(pend ? 7 : 3) || wr_req_o !== 1'b1) begin
                    failures++; $display("FAIL rr_addr got=%0d/%b exp=%0d/1", wr_addr_o, wr_req_o, pend ? 7 : 3);
                end
                pend = -1;
            end
            if (alu_gnt_o || lsu_gnt_o) begin
`ifdef VRF_WARB_FIXED_PRIO_EN
                exp_src = 0;
`else
                exp_src = ng % 2;
`endif
                gexp = (exp_src == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({alu_gnt_o, lsu_gnt_o} !== gexp) begin
                    failures++; $display("FAIL rr_gnt n=%0d got=%b exp=%b", ng, {alu_gnt_o, lsu_gnt_o}, gexp);
                end
                pend = exp_src;
                ng++;
            end
            tick();
        end
        checks++;
        if (ng != 4) begin failures++; $display("FAIL rr_timeout grants=%0d exp=4", ng); end
    endtask

    task automatic test_valid_gap();
        logic [5:0] act, exp;
        int k;
        logic en;
        do_reset();
        lsu_req_i = 1; lsu_addr_i = 9; lsu_valid_i = 1; lsu_data_i = 32'hB0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            en = (c == 2 || c == 3 || c == 7 || c == 8);
            @(negedge clk_i);
            act = {lsu_gnt_o, wr_req_o, wr_en_o, lsu_ready_o, wr_ready_o, busy_o};
            exp = {c == 0, c == 1, en, en, c == 8, c >= 1 && c <= 8};
            checks++;
            if (act !== exp) begin failures++; $display("FAIL gap_ctl c=%0d got=%b exp=%b", c, act, exp); end
            if (c >= 2 && c <= 8) begin
                checks++;
                if (wr_elem_cnt_o !== EB'(k) || (en && wdata_o !== 32'hB0 + DW'(k))) begin
                    failures++; $display("FAIL gap_data c=%0d got=%0d/%h exp=%0d/%h", c, wr_elem_cnt_o, wdata_o, k, 32'hB0 + k);
                end
            end
            if (en) k++;
            tick();
            lsu_req_i   = 0;
            lsu_valid_i = !(c + 1 >= 4 && c + 1 <= 6);
            lsu_data_i  = 32'hB0 + DW'(k);
        end
    endtask

    task automatic test_late_req();
        logic [5:0] act, exp;
        do_reset();
        alu_req_i = 1; alu_addr_i = 4; alu_valid_i = 1; alu_data_i = 32'h44;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            act = {alu_gnt_o, lsu_gnt_o, lsu_ready_o, wr_ready_o, wr_req_o, busy_o};
            exp = {c == 0, c == 6, c == 8, c == 5, c == 1 || c == 7, c != 0 && c != 6};
            checks++;
            if (act !== exp) begin failures++; $display("FAIL late_ctl c=%0d got=%b exp=%b", c, act, exp); end
            if (c == 7) begin
                checks++;
                if (wr_addr_o !== AB'(11)) begin failures++; $display("FAIL late_addr got=%0d exp=11", wr_addr_o); end
            end
            tick();
            alu_req_i = 0;
            if (c == 2) begin lsu_req_i = 1; lsu_addr_i = 11; lsu_valid_i = 1; lsu_data_i = 32'h55; end
            if (c == 6) lsu_req_i = 0;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] act;
        logic en;
        do_reset();
        alu_req_i = 1; alu_addr_i = 2; alu_valid_i = 1; alu_data_i = 32'hC0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            tick();
            alu_req_i = 0;
        end
        resetn_i = 0; alu_valid_i = 0;
        @(negedge clk_i);
        checks++;
        if ({wr_ready_o, wr_en_o} !== 2'b00) begin failures++; $display("FAIL rstmid_ready got=%b exp=00", {wr_ready_o, wr_en_o}); end
        tick();
        resetn_i = 1;
        @(negedge clk_i);
        act = {busy_o, wr_ready_o, wr_elem_cnt_o};
        checks++;
        if (act !== '0) begin failures++; $display("FAIL rstmid_state got=%b exp=0000", act); end
        tick();
        alu_req_i = 1; alu_addr_i = 6; alu_valid_i = 1; alu_data_i = 32'hE0;
        for (int c = 0; c < 7; c++) begin
            en = (c >= 2 && c <= 5);
            @(negedge clk_i);
            checks++;
            if ({wr_en_o, wr_ready_o, busy_o} !== {en, c == 5, c >= 1 && c <= 5} ||
                (en && {wr_elem_cnt_o, wr_addr_o, wdata_o} !== {EB'(c - 2), AB'(6), 32'hE0 + DW'(c - 2)})) begin
                failures++;
                $display("FAIL rstmid_redo c=%0d got=%b/%0d/%0d/%h", c, {wr_en_o, wr_ready_o, busy_o}, wr_elem_cnt_o, wr_addr_o, wdata_o);
            end
            tick();
            alu_req_i  = 0;
            alu_data_i = 32'hE0 + DW'((c >= 1) ? c - 1 : 0);
        end
    endtask

    task automatic test_stray_valid();
        logic en;
        do_reset();
        lsu_req_i = 1; lsu_addr_i = 13; lsu_valid_i = 1; lsu_data_i = 32'hD0;
        alu_valid_i = 1; alu_data_i = 32'hDEAD_BEEF;
        for (int c = 0; c < 7; c++) begin
            en = (c >= 2 && c <= 5);
            @(negedge clk_i);
            checks++;
            if ({alu_gnt_o, alu_ready_o, lsu_ready_o} !== {1'b0, 1'b0, en} || (en && wdata_o !== 32'hD0 + DW'(c - 2))) begin
                failures++;
                $display("FAIL stray c=%0d got=%b/%h exp=%b/%h", c, {alu_gnt_o, alu_ready_o, lsu_ready_o}, wdata_o, {2'b00, en}, 32'hD0 + c - 2);
            end
            tick();
            lsu_req_i  = 0;
            lsu_data_i = 32'hD0 + DW'((c >= 1) ? c - 1 : 0);
        end
    endtask

    task automatic test_random();
        logic [1:0]    r_req, own, r_val;
        logic [AB-1:0] r_addr [2];
        logic [DW-1:0] vec [2][LANES];
        logic [DW-1:0] r_dat [2];
        logic [7:0]    act, exp;
        logic [DW+AB+EB-1:0] dact, dexp;
        logic          exp_acc;
        int idx, owner, stage, ptr, win, done;
        do_reset();
        r_req = '0; own = '0; idx = 0; owner = 0; stage = 0; ptr = 0; done = 0;
        r_addr[0] = '0; r_addr[1] = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!own[s] && !r_req[s] && $urandom_range(0, 3) == 0) begin
                    r_req[s]  = 1;
                    r_addr[s] = AB'($urandom);
                    for (int l = 0; l < LANES; l++) vec[s][l] = $urandom;
                end
                if (own[s]) begin
                    r_val[s] = ($urandom_range(0, 9) < 7);
                    r_dat[s] = vec[s][idx];
                end else begin
                    r_val[s] = ($urandom_range(0, 9) < 2);
                    r_dat[s] = $urandom;
                end
            end
            alu_req_i = r_req[0]; alu_addr_i = r_addr[0]; alu_valid_i = r_val[0]; alu_data_i = r_dat[0];
            lsu_req_i = r_req[1]; lsu_addr_i = r_addr[1]; lsu_valid_i = r_val[1]; lsu_data_i = r_dat[1];
            // Expected winner from the arbitration rule: sole requester wins, otherwise the preferred one.
            win = -1;
            if (stage == 0 && r_req != 2'b00) begin
`ifdef VRF_WARB_FIXED_PRIO_EN
                win = (r_req == 2'b11) ? 0 : (r_req[1] ? 1 : 0);
`else
                win = (r_req == 2'b11) ? ptr : (r_req[1] ? 1 : 0);
`endif
            end
            exp_acc = (stage == 2) && r_val[owner];
            @(negedge clk_i);
            act = {alu_gnt_o, lsu_gnt_o, wr_req_o, wr_en_o, alu_ready_o, lsu_ready_o, wr_ready_o, busy_o};
            exp = {win == 0, win == 1, stage == 1, exp_acc, exp_acc && owner == 0, exp_acc && owner == 1,
                   exp_acc && idx == LANES - 1, stage != 0};
            checks++;
            if (act !== exp) begin failures++; $display("FAIL rand_ctl c=%0d got=%b exp=%b", c, act, exp); end
            if (exp_acc) begin
                dact = {wr_elem_cnt_o, wr_addr_o, wdata_o};
                dexp = {EB'(idx), r_addr[owner], vec[owner][idx]};
                checks++;
                if (dact !== dexp) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, dact, dexp); end
            end
            tick();
            if (win >= 0) begin
                stage = 1; owner = win; own[win] = 1; r_req[win] = 0; idx = 0;
            end else if (stage == 1) begin
                stage = 2;
            end else if (exp_acc) begin
                idx++;
                if (idx == LANES) begin
                    own[owner] = 0; stage = 0; ptr ^= 1; done++;
                end
            end
        end
        checks++;
        if (done < 20) begin failures++; $display("FAIL rand_progress vectors=%0d exp>=20", done); end
    endtask

    initial begin
        resetn_i = 0;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_rr();
        test_valid_gap();
        test_late_req();
        test_reset_mid();
        test_stray_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
